// File: rtl/h264ctxstore.sv
// Neighbour-context store: top-row luma/chroma pixels, top 4x4 modes, top/left nC, each entry with a slice-scoped valid bit.
// Latency: every read output is registered, 1 cycle from address (counter, XX/NX/NY, NV) to data; reads are read-first against same-cycle writes.
// Backpressure: none; every strobe and counter advance is accepted in its cycle.
//
// Ports:
//   CLK2, RESET            sole clock, synchronous active-high reset
//   NEWSLICE, NEWLINE      slice / line start pulses (clear counters; slice also clears all valid bits)
//   LXINC LXX LWSTROBE LWDATA MWSTROBE MWDATA -> LTOP LTOPV LTOPM   luma top pixels and 4x4 modes
//   CXINC CXX CWSTROBE CWDATA                 -> CTOP CTOPV         chroma top pixels
//   NXINC NX NY NV NLOAD NDATA                -> NOUT               nC store and prediction
//   OVERRUN                sticky: a counter was advanced while already at the last macroblock
module h264ctxstore #(
    parameter int IMGWIDTH = 352,
    parameter int IWBITS   = 9,
    parameter int NCBITS   = 5
) (
    input  logic              CLK2,
    input  logic              RESET,
    input  logic              NEWSLICE,
    input  logic              NEWLINE,
    // luma
    input  logic              LXINC,
    input  logic [1:0]        LXX,
    input  logic              LWSTROBE,
    input  logic [31:0]       LWDATA,
    input  logic              MWSTROBE,
    input  logic [3:0]        MWDATA,
    output logic [31:0]       LTOP,
    output logic              LTOPV,
    output logic [3:0]        LTOPM,
    // chroma
    input  logic              CXINC,
    input  logic [1:0]        CXX,
    input  logic              CWSTROBE,
    input  logic [31:0]       CWDATA,
    output logic [31:0]       CTOP,
    output logic              CTOPV,
    // nC
    input  logic              NXINC,
    input  logic [2:0]        NX,
    input  logic [2:0]        NY,
    input  logic [1:0]        NV,
    input  logic              NLOAD,
    input  logic [NCBITS-1:0] NDATA,
    output logic [NCBITS-1:0] NOUT,
    // status
    output logic              OVERRUN
);

    localparam int MBW    = IMGWIDTH / 16;
    localparam int LDEPTH = MBW * 4;
    localparam int NDEPTH = MBW * 8;
    localparam int LAW    = $clog2(LDEPTH);
    localparam int NAW    = $clog2(NDEPTH);

    localparam logic [IWBITS-1:0] MB_LAST   = IWBITS'(MBW - 1);
    localparam logic [31:0]       PIX_DFLT  = 32'h8080_8080;
    localparam logic [3:0]        MODE_DFLT = 4'd2;   // DC prediction

    // ------------------------------------------------------------------
    // Macroblock counters
    // ------------------------------------------------------------------
    logic [IWBITS-1:0] mbx;
    logic [IWBITS-1:0] mbxcc;
    logic [IWBITS-1:0] ninx;

    // An advance at the last macroblock is an overflow only when no line or
    // slice start in the same cycle is already returning the counter to 0.
    logic line_clr;
    logic l_ovf;
    logic c_ovf;
    logic n_ovf;

    assign line_clr = NEWSLICE || NEWLINE;
    assign l_ovf    = !line_clr && LXINC && (mbx   == MB_LAST);
    assign c_ovf    = !line_clr && CXINC && (mbxcc == MB_LAST);
    assign n_ovf    = !line_clr && NXINC && (ninx  == MB_LAST);

    always_ff @(posedge CLK2) begin
        if (RESET) begin
            mbx     <= '0;
            mbxcc   <= '0;
            ninx    <= '0;
            OVERRUN <= 1'b0;
        end else begin
            if (line_clr) begin
                mbx   <= '0;
                mbxcc <= '0;
                ninx  <= '0;
            end else begin
                // Saturate at the last macroblock rather than wrapping.
                if (LXINC && (mbx   != MB_LAST)) mbx   <= mbx + 1'b1;
                if (CXINC && (mbxcc != MB_LAST)) mbxcc <= mbxcc + 1'b1;
                if (NXINC && (ninx  != MB_LAST)) ninx  <= ninx + 1'b1;
            end

            if (NEWSLICE) begin
                OVERRUN <= 1'b0;
            end else if (l_ovf || c_ovf || n_ovf) begin
                OVERRUN <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Addresses. Counters never exceed MBW-1, so the truncated address
    // always lies inside the array depth.
    // ------------------------------------------------------------------
    logic [LAW-1:0] l_addr;
    logic [LAW-1:0] c_addr;
    logic [NAW-1:0] n_addr;

    assign l_addr = LAW'({mbx, LXX});
    assign c_addr = LAW'({mbxcc, CXX});
    assign n_addr = NAW'({ninx, NX});

    // Writes coinciding with a slice start (or reset) belong to the old slice
    // and are dropped entirely, both data and valid bit.
    logic wr_ok;
    assign wr_ok = !RESET && !NEWSLICE;

    // ------------------------------------------------------------------
    // Data storage (never cleared)
    // ------------------------------------------------------------------
    logic [31:0]       luma_ram  [0:LDEPTH-1];
    logic [3:0]        mode_ram  [0:LDEPTH-1];
    logic [31:0]       chrom_ram [0:LDEPTH-1];
    logic [NCBITS-1:0] ntop_ram  [0:NDEPTH-1];
    logic [NCBITS-1:0] nleft_ram [0:7];

    always_ff @(posedge CLK2) begin
        if (wr_ok && LWSTROBE) luma_ram[l_addr]  <= LWDATA;
        if (wr_ok && MWSTROBE) mode_ram[l_addr]  <= MWDATA;
        if (wr_ok && CWSTROBE) chrom_ram[c_addr] <= CWDATA;
        if (wr_ok && NLOAD) begin
            ntop_ram[n_addr] <= NDATA;
            nleft_ram[NY]    <= NDATA;
        end
    end

    // ------------------------------------------------------------------
    // Validity flops
    // ------------------------------------------------------------------
    logic [LDEPTH-1:0] luma_vld;
    logic [LDEPTH-1:0] mode_vld;
    logic [LDEPTH-1:0] chrom_vld;
    logic [NDEPTH-1:0] ntop_vld;
    logic [7:0]        nleft_vld;

    always_ff @(posedge CLK2) begin
        if (RESET || NEWSLICE) begin
            luma_vld  <= '0;
            mode_vld  <= '0;
            chrom_vld <= '0;
            ntop_vld  <= '0;
            nleft_vld <= '0;
        end else begin
            if (LWSTROBE) luma_vld[l_addr]  <= 1'b1;
            if (MWSTROBE) mode_vld[l_addr]  <= 1'b1;
            if (CWSTROBE) chrom_vld[c_addr] <= 1'b1;
            if (NLOAD)    ntop_vld[n_addr]  <= 1'b1;
            // Left context belongs to the current line: a line start wins
            // over a coincident left store.
            if (NEWLINE) begin
                nleft_vld <= '0;
            end else if (NLOAD) begin
                nleft_vld[NY] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // nC prediction with availability
    // ------------------------------------------------------------------
    logic [NCBITS-1:0] nc_l;
    logic [NCBITS-1:0] nc_t;
    logic              nc_lv;
    logic              nc_tv;
    logic [NCBITS:0]   nc_sum;
    logic [NCBITS-1:0] nc_pred;

    always_comb begin
        nc_l    = nleft_ram[NY];
        nc_t    = ntop_ram[n_addr];
        nc_lv   = nleft_vld[NY];
        nc_tv   = ntop_vld[n_addr];
        // One extra bit so l+t+1 cannot wrap before the halving.
        nc_sum  = {1'b0, nc_l} + {1'b0, nc_t} + (NCBITS+1)'(1);
        nc_pred = '0;
        case (NV)
            2'd1: nc_pred = nc_lv ? nc_l : '0;
            2'd2: nc_pred = nc_tv ? nc_t : '0;
            2'd3: begin
                if (nc_lv && nc_tv) begin
                    nc_pred = NCBITS'(nc_sum >> 1);
                end else if (nc_lv) begin
                    nc_pred = nc_l;
                end else if (nc_tv) begin
                    nc_pred = nc_t;
                end
            end
            default: nc_pred = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered read outputs. Sampling storage and valid bits before this
    // edge's writes land gives read-first behaviour for free.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK2) begin
        if (RESET) begin
            LTOP  <= '0;
            LTOPV <= 1'b0;
            LTOPM <= '0;
            CTOP  <= '0;
            CTOPV <= 1'b0;
            NOUT  <= '0;
        end else begin
            LTOP  <= luma_vld[l_addr]  ? luma_ram[l_addr]  : PIX_DFLT;
            LTOPV <= luma_vld[l_addr];
            LTOPM <= mode_vld[l_addr]  ? mode_ram[l_addr]  : MODE_DFLT;
            CTOP  <= chrom_vld[c_addr] ? chrom_ram[c_addr] : PIX_DFLT;
            CTOPV <= chrom_vld[c_addr];
            // A store cycle is not a prediction cycle; the last prediction holds.
            if (!NLOAD) NOUT <= nc_pred;
        end
    end

endmodule
